// File: rtl/ctd_seg_scan.sv
// Two-digit multiplexed 7-segment driver with a bounded blink alarm on timer expiry.
// Optional macro CTD_LEAD_BLANK_EN blanks a leading zero in the tens digit outside ALARM.
module ctd_seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_TICKS  = 250,
  parameter int ALARM_HALVES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       time_out,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       alarm
);

  localparam int SC_W = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, ALARM} state_t;

  state_t      state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic        d_q, d_d;
  logic [7:0]  val_q, val_d;
  logic [7:0]  halves_q, halves_d;
  logic [9:0]  bt_q, bt_d;
  logic        dark_q, dark_d;
  logic [1:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        alarm_q, alarm_d;
  logic        wrap;
  logic [3:0]  digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sc_q     <= '0;
      d_q      <= 1'b0;
      val_q    <= 8'h00;
      halves_q <= 8'd0;
      bt_q     <= 10'd0;
      dark_q   <= 1'b0;
      an_q     <= 2'b11;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      d_q      <= d_d;
      val_q    <= val_d;
      halves_q <= halves_d;
      bt_q     <= bt_d;
      dark_q   <= dark_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      alarm_q  <= alarm_d;
    end
  end

  // Latching only at the tens->units wrap keeps both digits of a frame from the same value.
  always_comb begin
    wrap     = (sc_q == SC_W'(SCAN_DIV - 1));
    sc_d     = wrap ? '0 : sc_q + 1'b1;
    d_d      = wrap ? ~d_q : d_q;
    val_d    = (wrap && d_q) ? bcd_in : val_q;
    state_d  = state_q;
    halves_d = halves_q;
    bt_d     = bt_q;
    dark_d   = dark_q;
    if (time_out) begin
      state_d  = ALARM;
      halves_d = 8'(ALARM_HALVES);
      bt_d     = 10'd0;
      dark_d   = 1'b1;
    end else if (state_q == ALARM && wrap) begin
      if (bt_q == 10'(BLINK_TICKS - 1)) begin
        bt_d   = 10'd0;
        dark_d = ~dark_q;
        if (halves_q == 8'd1) begin
          state_d  = IDLE;
          halves_d = 8'd0;
          dark_d   = 1'b0;
        end else begin
          halves_d = halves_q - 8'd1;
        end
      end else begin
        bt_d = bt_q + 10'd1;
      end
    end
  end

  always_comb begin
    digit   = d_q ? val_q[7:4] : val_q[3:0];
    seg_d   = seg_decode(digit);
`ifdef CTD_LEAD_BLANK_EN
    if (d_q && val_q[7:4] == 4'd0 && state_q != ALARM) seg_d = 7'h7F;
`else
    seg_d   = seg_decode(digit);
`endif
    an_d    = dark_q ? 2'b11 : (d_q ? 2'b01 : 2'b10);
    dp_d    = !(state_q == ALARM && !d_q && !dark_q);
    alarm_d = (state_q == ALARM);
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_ctd_seg_scan.sv
// Randomized self-checking bench for ctd_seg_scan against a cycle-count based reference model.
// Honours CTD_LEAD_BLANK_EN the same way as the design build.
module tb_ctd_seg_scan;
  localparam int SD = 4;
  localparam int BT = 2;
  localparam int AH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       time_out;
  logic [7:0] bcd_in;
  logic [1:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release, latched frame value, alarm flag, wraps since alarm entry.
  int         m_n;
  logic [7:0] m_val;
  bit         m_alarm;
  int         m_wraps;
  logic [1:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_alarm;
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  ctd_seg_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT), .ALARM_HALVES(AH)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .time_out(time_out),
    .an(an), .seg(seg), .dp(dp), .alarm(alarm)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Outputs on an edge reflect the model state that held before that edge.
  task automatic modelStep(input logic r, input logic t, input logic [7:0] b);
    int  d;
    bit  dark;
    logic [3:0] digit;
    if (r) begin
      e_an = 2'b11; e_seg = 7'h7F; e_dp = 1'b1; e_alarm = 1'b0;
      m_n = 0; m_val = 8'h00; m_alarm = 0; m_wraps = 0;
      return;
    end
    d     = (m_n / SD) % 2;
    dark  = m_alarm && ((m_wraps / BT) % 2 == 0);
    e_an  = dark ? 2'b11 : (d == 1 ? 2'b01 : 2'b10);
    digit = (d == 1) ? m_val[7:4] : m_val[3:0];
    e_seg = seg_tab[digit];
`ifdef CTD_LEAD_BLANK_EN
    if (d == 1 && m_val[7:4] == 4'd0 && !m_alarm) e_seg = 7'h7F;
`endif
    e_dp    = !(m_alarm && d == 0 && !dark);
    e_alarm = m_alarm;
    if ((m_n % SD) == SD - 1) begin
      if (d == 1) m_val = b;
      if (m_alarm && !t) begin
        m_wraps++;
        if (m_wraps == AH * BT) m_alarm = 0;
      end
    end
    if (t) begin
      m_alarm = 1;
      m_wraps = 0;
    end
    m_n++;
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic [7:0] b);
    rst = r; time_out = t; bcd_in = b;
    @(posedge clk);
    modelStep(r, t, b);
    @(negedge clk);
    checkOutput("an", int'(an), int'(e_an));
    checkOutput("seg", int'(seg), int'(e_seg));
    checkOutput("dp", int'(dp), int'(e_dp));
    checkOutput("alarm", int'(alarm), int'(e_alarm));
  endtask

  initial begin
    logic [7:0] b;
    logic       r;
    logic       t;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    m_n = 0; m_val = 8'h00; m_alarm = 0; m_wraps = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h37);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 8'h37);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 8'h25);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 8'h26);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 8'h9C);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 8'h05);

    applyStimulus(1'b0, 1'b1, 8'h05);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 8'h05);

    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 8'h00);

    applyStimulus(1'b0, 1'b1, 8'h48);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h48);
    applyStimulus(1'b1, 1'b0, 8'h48);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h48);
    applyStimulus(1'b1, 1'b1, 8'h48);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h48);

    b = 8'h12;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 149) == 0);
      t = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
      applyStimulus(r, t, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
